// File: rtl/audio_frame_buffer_if.sv
// Sample-stream and frame-reader signals of audio_frame_buffer, grouped as one bus.
// The DUT takes the slave modport; the producer/consumer side drives the master modport.
interface audio_frame_buffer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CH_NUM = 2,
    parameter int unsigned ADDR_W = 10
);
    logic                     smp_valid_i;
    logic [CH_NUM*DATA_W-1:0] smp_data_i;
    logic [ADDR_W-1:0]        rd_addr_i;
    logic [DATA_W-1:0]        rd_data_o;
    logic                     rd_done_i;
    logic                     frame_start_o;
    logic                     rd_bank_o;
    logic                     busy_o;
    logic                     overrun_o;

    modport master (
        output smp_valid_i,
        output smp_data_i,
        output rd_addr_i,
        output rd_done_i,
        input  rd_data_o,
        input  frame_start_o,
        input  rd_bank_o,
        input  busy_o,
        input  overrun_o
    );

    modport slave (
        input  smp_valid_i,
        input  smp_data_i,
        input  rd_addr_i,
        input  rd_done_i,
        output rd_data_o,
        output frame_start_o,
        output rd_bank_o,
        output busy_o,
        output overrun_o
    );
endinterface

// File: rtl/audio_frame_buffer.sv
// Ping-pong capture buffer: codec samples (channel select or mono mix, decimated) into
// two RAM banks handed alternately to the FFT reader. AFB_DROP_CNT_EN adds drop/fill status.
module audio_frame_buffer #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned CH_NUM   = 2,
    parameter int unsigned CH_SEL_W = 1,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    audio_frame_buffer_if.slave bus_if,
    input  logic                mode_i,
    input  logic [CH_SEL_W-1:0] ch_sel_i,
    input  logic [3:0]          decim_i
`ifdef AFB_DROP_CNT_EN
    ,
    output logic [15:0]         drop_cnt_o,
    output logic [ADDR_W:0]     fill_level_o
`endif
);

    localparam int unsigned SumW = DATA_W + CH_SEL_W;

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e                state_q, state_d;
    logic                  cfg_load_q;
    logic                  mode_q;
    logic [CH_SEL_W-1:0]   ch_sel_q;
    logic [3:0]            decim_q;
    logic                  mode_eff;
    logic [CH_SEL_W-1:0]   ch_sel_eff;
    logic [3:0]            decim_eff;
    logic [3:0]            dec_cnt_q, dec_cnt_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic                  frame_start_q, frame_start_d;
    logic                  overrun_q, overrun_d;
    logic                  accept;
    logic                  last_wr;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W-1:0]     rd_data_q;
    logic signed [SumW-1:0] mix_sum;
    logic signed [SumW-1:0] mix_avg;
    logic signed [SumW-1:0] ch_ext;

    logic [DATA_W-1:0] mem [2**(ADDR_W+1)];

    // Right after reset the latch has not happened yet, so the live inputs are used.
    assign mode_eff   = cfg_load_q ? mode_i   : mode_q;
    assign ch_sel_eff = cfg_load_q ? ch_sel_i : ch_sel_q;
    assign decim_eff  = cfg_load_q ? decim_i  : decim_q;

    assign accept  = bus_if.smp_valid_i && (dec_cnt_q == 4'd0);
    assign last_wr = accept && (wr_addr_q == {ADDR_W{1'b1}});

    // Mono mix: exact sum in DATA_W+CH_SEL_W bits, floor-divided by CH_NUM.
    always_comb begin
        mix_sum = '0;
        ch_ext  = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            ch_ext  = {{CH_SEL_W{bus_if.smp_data_i[c*DATA_W+DATA_W-1]}},
                       bus_if.smp_data_i[c*DATA_W +: DATA_W]};
            mix_sum = mix_sum + ch_ext;
        end
        mix_avg = mix_sum >>> CH_SEL_W;
    end

    assign wr_data = mode_eff ? mix_avg[DATA_W-1:0]
                              : bus_if.smp_data_i[ch_sel_eff*DATA_W +: DATA_W];

    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        dec_cnt_d     = dec_cnt_q;
        frame_start_d = 1'b0;
        overrun_d     = 1'b0;

        if (bus_if.smp_valid_i) begin
            dec_cnt_d = (dec_cnt_q >= decim_eff) ? 4'd0 : dec_cnt_q + 4'd1;
        end
        if (accept) begin
            wr_addr_d = wr_addr_q + 1'b1;
        end
        if (last_wr) begin
            dec_cnt_d = 4'd0;
        end

        unique case (state_q)
            StIdle: begin
                if (last_wr) begin
                    state_d       = StHold;
                    rd_bank_d     = wr_bank_q;
                    wr_bank_d     = ~wr_bank_q;
                    frame_start_d = 1'b1;
                end
            end
            StHold: begin
                if (last_wr && bus_if.rd_done_i) begin
                    // Release and handoff in one cycle: reader gets the fresh bank directly.
                    rd_bank_d     = wr_bank_q;
                    wr_bank_d     = ~wr_bank_q;
                    frame_start_d = 1'b1;
                end else if (last_wr) begin
                    overrun_d = 1'b1;
                end else if (bus_if.rd_done_i) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            wr_addr_q     <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            dec_cnt_q     <= 4'd0;
            frame_start_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            dec_cnt_q     <= dec_cnt_d;
            frame_start_q <= frame_start_d;
            overrun_q     <= overrun_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_load_q <= 1'b1;
            mode_q     <= 1'b0;
            ch_sel_q   <= '0;
            decim_q    <= 4'd0;
        end else begin
            cfg_load_q <= 1'b0;
            if (cfg_load_q || last_wr) begin
                mode_q   <= mode_i;
                ch_sel_q <= ch_sel_i;
                decim_q  <= decim_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[{wr_bank_q, wr_addr_q}] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[{rd_bank_q, bus_if.rd_addr_i}];
        end
    end

    assign bus_if.rd_data_o     = rd_data_q;
    assign bus_if.frame_start_o = frame_start_q;
    assign bus_if.rd_bank_o     = rd_bank_q;
    assign bus_if.busy_o        = (state_q == StHold);
    assign bus_if.overrun_o     = overrun_q;

`ifdef AFB_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 16'd0;
        end else if (overrun_d && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt_o   = drop_cnt_q;
    assign fill_level_o = {1'b0, wr_addr_q};
`endif

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Self-checking bench for audio_frame_buffer (ADDR_W=3): expected frame contents are queued
// as samples are driven and compared against registered read data.
module tb_audio_frame_buffer;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned CH_NUM   = 2;
    localparam int unsigned CH_SEL_W = 1;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned Frame    = 2**ADDR_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                mode;
    logic [CH_SEL_W-1:0] ch_sel;
    logic [3:0]          decim;
`ifdef AFB_DROP_CNT_EN
    logic [15:0]         drop_cnt;
    logic [ADDR_W:0]     fill_level;
`endif

    audio_frame_buffer_if #(.DATA_W(DATA_W), .CH_NUM(CH_NUM), .ADDR_W(ADDR_W)) bus_if ();

    audio_frame_buffer #(
        .DATA_W  (DATA_W),
        .CH_NUM  (CH_NUM),
        .CH_SEL_W(CH_SEL_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus_if  (bus_if),
        .mode_i  (mode),
        .ch_sel_i(ch_sel),
        .decim_i (decim)
`ifdef AFB_DROP_CNT_EN
        ,
        .drop_cnt_o  (drop_cnt),
        .fill_level_o(fill_level)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] frame_q[$];   // expected contents of the frame being written
    logic [DATA_W-1:0] rd_exp_q[$];  // expected read data in flight
    logic [DATA_W-1:0] held[Frame];  // expected contents of the bank the reader holds

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [DATA_W-1:0] c0, input logic [DATA_W-1:0] c1);
        bus_if.smp_valid_i = 1'b1;
        bus_if.smp_data_i  = {c1, c0};
        tick();
        bus_if.smp_valid_i = 1'b0;
    endtask

    task automatic capture();
        for (int i = 0; i < Frame; i++) begin
            held[i] = frame_q.pop_front();
        end
    endtask

    task automatic read_frame(input string tag);
        for (int i = 0; i < Frame; i++) begin
            bus_if.rd_addr_i = ADDR_W'(i);
            rd_exp_q.push_back(held[i]);
            tick();
            check(tag, 32'(bus_if.rd_data_o), 32'(rd_exp_q.pop_front()));
        end
    endtask

    task automatic release_bank();
        bus_if.rd_done_i = 1'b1;
        tick();
        bus_if.rd_done_i = 1'b0;
        check("release_busy", 32'(bus_if.busy_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int ma[8] = '{-3, 5, -1, 32767, -32768, -32768, 7, 100};
        int mb[8] = '{0, 4, -1, 32767, -32768, 32767, -8, -50};

        bus_if.smp_valid_i = 1'b0;
        bus_if.smp_data_i  = '0;
        bus_if.rd_addr_i   = '0;
        bus_if.rd_done_i   = 1'b0;
        mode   = 1'b0;
        ch_sel = 1'b1;
        decim  = 4'd0;
        repeat (2) tick();

        check("rst_data", 32'(bus_if.rd_data_o), 32'd0);
        check("rst_flags", 32'({bus_if.frame_start_o, bus_if.rd_bank_o, bus_if.busy_o,
                                bus_if.overrun_o}), 32'd0);
        rst_n = 1'b1;

        // Frame A: channel 1; mode change mid-frame applies only to the next frame.
        for (int i = 0; i < 8; i++) begin
            if (i == 3) mode = 1'b1;
            strobe(16'(100 + i), 16'(i + 1));
            frame_q.push_back(16'(i + 1));
            check("a_fs", 32'(bus_if.frame_start_o), 32'(i == 7));
        end
        check("a_bank", 32'(bus_if.rd_bank_o), 32'd0);
        check("a_busy", 32'(bus_if.busy_o), 32'd1);
        capture();
        read_frame("a_rd");
        check("a_fs_off", 32'(bus_if.frame_start_o), 32'd0);
        release_bank();

        // Frame B: mono mix into bank 1.
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                mode   = 1'b0;
                ch_sel = 1'b0;
                decim  = 4'd2;
            end
            strobe(16'(ma[i]), 16'(mb[i]));
            frame_q.push_back(16'((ma[i] + mb[i]) >>> 1));
            check("b_fs", 32'(bus_if.frame_start_o), 32'(i == 7));
        end
        check("b_bank", 32'(bus_if.rd_bank_o), 32'd1);
        capture();
        read_frame("b_rd");
        release_bank();

        // Frame C: decimate by 3; decim 0 latched at its boundary for the following frame.
        for (int i = 0; i < 24; i++) begin
            if (i == 21) decim = 4'd0;
            strobe(16'(i), 16'hBEEF);
            if (i > 21 || (i % 3) == 0) frame_q.push_back(16'(i));
            check("c_fs", 32'(bus_if.frame_start_o), 32'(i == 21));
            if (i == 21) capture();
        end
        check("c_bank", 32'(bus_if.rd_bank_o), 32'd0);
`ifdef AFB_DROP_CNT_EN
        check("c_fill", 32'(fill_level), 32'd2);
`endif
        read_frame("c_rd");

        // Overrun: finish the next frame while C is still held.
        for (int i = 0; i < 6; i++) begin
            strobe(16'(50 + i), 16'h0);
            check("ovr_pulse", 32'(bus_if.overrun_o), 32'(i == 5));
            check("ovr_fs", 32'(bus_if.frame_start_o), 32'd0);
        end
        frame_q.delete();
        tick();
        check("ovr_once", 32'(bus_if.overrun_o), 32'd0);
        check("ovr_busy", 32'(bus_if.busy_o), 32'd1);
        check("ovr_bank", 32'(bus_if.rd_bank_o), 32'd0);
`ifdef AFB_DROP_CNT_EN
        check("ovr_drop", 32'(drop_cnt), 32'd1);
        check("ovr_fill", 32'(fill_level), 32'd0);
`endif
        read_frame("ovr_held");

        // Release coincides with the last write of the next frame.
        for (int i = 0; i < 8; i++) begin
            if (i == 7) bus_if.rd_done_i = 1'b1;
            strobe(16'(200 + i), 16'h0);
            bus_if.rd_done_i = 1'b0;
            frame_q.push_back(16'(200 + i));
            check("sim_fs", 32'(bus_if.frame_start_o), 32'(i == 7));
            check("sim_ovr", 32'(bus_if.overrun_o), 32'd0);
        end
        check("sim_bank", 32'(bus_if.rd_bank_o), 32'd1);
        check("sim_busy", 32'(bus_if.busy_o), 32'd1);
`ifdef AFB_DROP_CNT_EN
        check("sim_drop", 32'(drop_cnt), 32'd1);
`endif
        capture();
        read_frame("sim_rd");

        // Reset in the middle of a frame while a bank is held.
        for (int i = 0; i < 5; i++) begin
            strobe(16'(400 + i), 16'h0);
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", 32'(bus_if.rd_data_o), 32'd0);
        check("mid_rst_flags", 32'({bus_if.frame_start_o, bus_if.rd_bank_o, bus_if.busy_o,
                                    bus_if.overrun_o}), 32'd0);
`ifdef AFB_DROP_CNT_EN
        check("mid_rst_drop", 32'(drop_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        frame_q.delete();
        for (int i = 0; i < 8; i++) begin
            strobe(16'(300 + i), 16'h0);
            frame_q.push_back(16'(300 + i));
            check("post_fs", 32'(bus_if.frame_start_o), 32'(i == 7));
        end
        check("post_bank", 32'(bus_if.rd_bank_o), 32'd0);
        check("post_busy", 32'(bus_if.busy_o), 32'd1);
        capture();
        read_frame("post_rd");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/audio_frame_buffer.md
Name: audio_frame_buffer

Overview:
- Parametrised ping-pong capture buffer between the codec sample stream and the FFT engine.
- Supersedes the single-channel, fixed-length codec-side buffer.
- Supports N channels, selectable channel or averaged mono mix, sample decimation, and configurable frame length.
- Detects overrun when the FFT has not released the previous frame in time.

Parameters:
DATA_W, 16, sample width (two's complement)
CH_NUM, 2, channels per input word; power of two, >=2
CH_SEL_W, 1, log2(CH_NUM)
ADDR_W, 10, frame length = 2^ADDR_W samples per bank

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
smp_valid_i  in  1  one-cycle strobe: smp_data_i holds one sample per channel
smp_data_i  in  CH_NUM*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
mode_i  in  1  0 = single channel (ch_sel_i), 1 = mono mix of all channels
ch_sel_i  in  CH_SEL_W  channel index for mode 0
decim_i  in  4  keep 1 of every decim_i+1 strobes (0 = keep all)
rd_addr_i  in  ADDR_W  reader sample address within the held bank
rd_data_o  out  DATA_W  sample at rd_addr_i, registered
rd_done_i  in  1  one-cycle pulse: reader releases the held bank
frame_start_o  out  1  one-cycle pulse: new frame available to reader
rd_bank_o  out  1  bank currently owned by the reader
busy_o  out  1  reader holds a bank
overrun_o  out  1  one-cycle pulse: completed frame discarded

Behaviour:
- Reset values: all outputs 0, wr_bank=0, wr_addr=0, decimation counter=0, reader IDLE. RAM contents are not cleared.
- Reset asserted mid-frame: partial frame discarded; a held frame is released.
- Storage: 2 x 2^ADDR_W x DATA_W simple dual-port RAM. Write address {wr_bank, wr_addr}; read address {rd_bank_o, rd_addr_i}.
- Read latency: rd_data_o is valid 1 clk after rd_addr_i. Reads are legal only while busy_o=1; otherwise the data is don't-care.
- Config latch: mode_i, ch_sel_i and decim_i are latched at reset release and at every frame boundary (the cycle the last sample is written). Changes mid-frame take effect at the next frame.
- Decimation: the counter increments on each smp_valid_i and wraps after the latched decim value. A sample is accepted when the counter is 0. The counter is cleared at every frame boundary, so the first strobe after a boundary is always accepted.
- Sample select:
  - mode 0: stored = channel ch_sel.
  - mode 1: sign-extend every channel to DATA_W+CH_SEL_W, sum, then arithmetic shift right by CH_SEL_W (floor). Store the low DATA_W bits; no overflow is possible.
- Write: each accepted sample is written to wr_addr, then wr_addr increments. Writes always proceed; the writer never stalls.
- Reader FSM, IDLE -> HOLD:
  - Occurs on the accepted write at wr_addr = 2^ADDR_W-1 while IDLE.
  - rd_bank_o <= wr_bank, wr_bank toggles, wr_addr <= 0, busy_o <= 1.
  - frame_start_o pulses in the following cycle.
- Reader FSM, HOLD -> IDLE: on rd_done_i, busy_o <= 0 next cycle. rd_done_i while IDLE is ignored.
- Overrun: last write while HOLD and rd_done_i=0.
  - overrun_o pulses next cycle.
  - wr_addr wraps to 0 and the same bank is refilled.
  - The held bank is untouched.
- Simultaneous last write and rd_done_i in HOLD: the release is applied first and the handoff proceeds as from IDLE. There is no overrun; busy_o stays 1; rd_bank_o toggles; frame_start_o pulses.
- Pipelining: at most one register stage between smp_valid_i and the RAM write. A strobe every clock must be sustainable.

Optional Feature:
Macro AFB_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt_o, 16 bits: count of overrun events.
  - Saturates at 16'hFFFF; cleared only by rst_n.
  - Adds output fill_level_o, ADDR_W+1 bits: current wr_addr.
- Undefined: neither port exists; overrun_o is unchanged.

Test Plan:
- ADDR_W=3, mode 0, ch_sel 1, decim 0, 8 strobes with ch1 = 1..8 -> frame_start_o pulses 1 clk after the 8th write; rd_bank_o=0; reading addr 0..7 returns 1..8 at 1 clk latency.
- Mode 1, CH_NUM=2, pairs (-3,0), (5,4), (-1,-1), (32767,32767) -> stored -2, 4, -1, 32767.
- decim 2, 24 strobes, values 0..23 -> frame holds 0,3,6,...,21; frame_start_o occurs after the 22nd strobe.
- Hold frame without rd_done_i, 8 more accepted samples -> overrun_o pulses once; held bank data unchanged; with AFB_DROP_CNT_EN, drop_cnt_o=1.
- rd_done_i in the same cycle as the last write of the next frame -> no overrun_o; frame_start_o pulses; rd_bank_o toggles 0->1; busy_o stays 1.
- rst_n low for 1 clk after 5 writes while in HOLD -> all outputs 0; the next 8 strobes produce frame_start_o with rd_bank_o=0.
